// File: rtl/color_pkg.sv
// Shared palette constants and FSM state encodings for the digit colour encoder.
package color_pkg;

  localparam logic [11:0] COL_BLACK  = 12'h000;
  localparam logic [11:0] COL_BROWN  = 12'hF00;
  localparam logic [11:0] COL_RED    = 12'hF80;
  localparam logic [11:0] COL_ORANGE = 12'hFF0;
  localparam logic [11:0] COL_YELLOW = 12'h0F0;
  localparam logic [11:0] COL_GREEN  = 12'h0FF;
  localparam logic [11:0] COL_BLUE   = 12'h08F;
  localparam logic [11:0] COL_VIOLET = 12'h00F;
  localparam logic [11:0] COL_GREY   = 12'hF0F;
  localparam logic [11:0] COL_WHITE  = 12'hFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [11:0] default_color(input logic [3:0] d);
    case (d)
      4'd0:    return COL_BLACK;
      4'd1:    return COL_BROWN;
      4'd2:    return COL_RED;
      4'd3:    return COL_ORANGE;
      4'd4:    return COL_YELLOW;
      4'd5:    return COL_GREEN;
      4'd6:    return COL_BLUE;
      4'd7:    return COL_VIOLET;
      4'd8:    return COL_GREY;
      4'd9:    return COL_WHITE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/digit_palette.sv
// One BCD digit to one COLOR_W colour. With DIGIT_COLOR_PALETTE_WR_EN defined the
// palette is a writable 10-entry register file reset to the default table.
module digit_palette
  import color_pkg::*;
#(
  parameter int COLOR_W = 12
) (
`ifdef DIGIT_COLOR_PALETTE_WR_EN
  input  logic               clk,
  input  logic               rst,
  input  logic               pal_we,
  input  logic [3:0]         pal_addr,
  input  logic [COLOR_W-1:0] pal_data,
`endif
  input  logic [3:0]         digit,
  output logic [COLOR_W-1:0] color
);

  // 12-bit entries are left-aligned into COLOR_W: truncate low bits or pad with zeros.
  function automatic logic [COLOR_W-1:0] scale(input logic [11:0] c);
    logic [COLOR_W+11:0] t;
    t = {c, {COLOR_W{1'b0}}};
    return t[COLOR_W+11 -: COLOR_W];
  endfunction

`ifdef DIGIT_COLOR_PALETTE_WR_EN
  logic [COLOR_W-1:0] pal_rf [10];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) pal_rf[i] <= scale(default_color(4'(i)));
    end else if (pal_we) begin
      for (int i = 0; i < 10; i++)
        if (pal_addr == 4'(i)) pal_rf[i] <= pal_data;
    end
  end

  always_comb begin
    color = '0;
    for (int i = 0; i < 10; i++)
      if (digit == 4'(i)) color = pal_rf[i];
  end
`else
  assign color = scale(default_color(digit));
`endif

endmodule

// File: rtl/digit_color_seq.sv
// Sequential binary-to-BCD (double-dabble) encoder with per-digit palette colours.
// Optional writable palette via DIGIT_COLOR_PALETTE_WR_EN.
module digit_color_seq
  import color_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int DIGITS  = 3,
  parameter int COLOR_W = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DIGITS*COLOR_W-1:0]   code,
  output logic [DIGITS*4-1:0]         digits,
  output logic                        ovf
`ifdef DIGIT_COLOR_PALETTE_WR_EN
  ,
  input  logic                        pal_we,
  input  logic [3:0]                  pal_addr,
  input  logic [COLOR_W-1:0]          pal_data
`endif
);

  localparam int BCD_W = DIGITS * 4;
  localparam int SR_W  = BCD_W + IN_W;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS) - 64'd1;

  state_t                     state, state_nxt;
  logic [SR_W-1:0]            sr;
  logic [CNT_W-1:0]           iter;
  logic                       ovf_pend;
  logic [BCD_W-1:0]           bcd_adj;
  logic [SR_W-1:0]            sr_shift;
  logic [DIGITS*COLOR_W-1:0]  colors;
  logic                       iter_done;

  assign iter_done = (iter == CNT_W'(IN_W));

  always_comb begin
    bcd_adj = sr[SR_W-1 -: BCD_W];
    for (int d = 0; d < DIGITS; d++)
      if (bcd_adj[d*4 +: 4] >= 4'd5) bcd_adj[d*4 +: 4] = bcd_adj[d*4 +: 4] + 4'd3;
  end

  // The top BCD bit falls off here, which makes the result value mod 10^DIGITS.
  assign sr_shift = {bcd_adj[BCD_W-2:0], sr[IN_W-1:0], 1'b0};

  for (genvar g = 0; g < DIGITS; g++) begin : g_pal
    digit_palette #(.COLOR_W(COLOR_W)) u_pal (
`ifdef DIGIT_COLOR_PALETTE_WR_EN
      .clk      (clk),
      .rst      (rst),
      .pal_we   (pal_we),
      .pal_addr (pal_addr),
      .pal_data (pal_data),
`endif
      .digit    (sr[IN_W + g*4 +: 4]),
      .color    (colors[g*COLOR_W +: COLOR_W])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: if (iter_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are published only on DONE entry; ovf is staged until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '0;
      iter     <= '0;
      ovf_pend <= 1'b0;
      digits   <= '0;
      code     <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sr       <= {{BCD_W{1'b0}}, in_data};
          iter     <= '0;
          ovf_pend <= 64'(in_data) > MAX_VAL;
        end
        CONV: if (iter_done) begin
          digits <= sr[SR_W-1 -: BCD_W];
          code   <= colors;
          ovf    <= ovf_pend;
        end else begin
          sr   <= sr_shift;
          iter <= iter + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_color_seq.sv
// Directed self-checking bench: a DIGITS=3 and a DIGITS=2 instance on one clock/reset.
module tb_digit_color_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, out_valid, ovf;
  logic [35:0] code;
  logic [11:0] digits;

  logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [7:0]  in_data2 = '0;
  logic        in_ready2, out_valid2, ovf2;
  logic [23:0] code2;
  logic [7:0]  digits2;

`ifdef DIGIT_COLOR_PALETTE_WR_EN
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [11:0] pal_data = '0;
`endif

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  digit_color_seq #(.IN_W(8), .DIGITS(3), .COLOR_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .code(code), .digits(digits), .ovf(ovf)
`ifdef DIGIT_COLOR_PALETTE_WR_EN
    , .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
`endif
  );

  digit_color_seq #(.IN_W(8), .DIGITS(2), .COLOR_W(12)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .out_valid(out_valid2), .out_ready(out_ready2), .code(code2), .digits(digits2), .ovf(ovf2)
`ifdef DIGIT_COLOR_PALETTE_WR_EN
    , .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a value, then count edges after the accepting edge until out_valid.
  task automatic send1(input logic [7:0] v, output int n);
    @(negedge clk); in_valid = 1'b1; in_data = v;
    @(negedge clk); in_valid = 1'b0;
    chk("busy_after_accept", 64'(in_ready), 64'd0);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(negedge clk); n++;
      if (out_valid !== 1'b1) chk("busy_in_conv", 64'(in_ready), 64'd0);
    end
    chk("done_reached", 64'(n < 40), 64'd1);
  endtask

  task automatic hs1;
    chk("valid_before_hs", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    chk("valid_after_hs", 64'(out_valid), 64'd0);
    chk("ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  task automatic send2(input logic [7:0] v);
    int n;
    @(negedge clk); in_valid2 = 1'b1; in_data2 = v;
    @(negedge clk); in_valid2 = 1'b0;
    n = 0;
    while (out_valid2 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk("d2_done_reached", 64'(n), 64'd9);
  endtask

  task automatic hs2;
    out_ready2 = 1'b1;
    @(negedge clk); out_ready2 = 1'b0;
    chk("d2_ready_after_hs", 64'(in_ready2), 64'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_code", 64'(code), 64'd0);
    chk("rst_digits", 64'(digits), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk); rst = 1'b0;

    // 255: 2 -> F80, 5 -> 0FF
    send1(8'd255, lat);
    chk("t1_latency", 64'(lat), 64'd9);
    chk("t1_digits", 64'(digits), 64'h255);
    chk("t1_code", 64'(code), 64'hF80_0FF_0FF);
    chk("t1_ovf", 64'(ovf), 64'd0);
    hs1();
    chk("t1_hold_digits", 64'(digits), 64'h255);

    send1(8'd0, lat);
    chk("t2a_digits", 64'(digits), 64'h000);
    chk("t2a_code", 64'(code), 64'h000_000_000);
    hs1();
    send1(8'd47, lat);
    chk("t2b_digits", 64'(digits), 64'h047);
    chk("t2b_code", 64'(code), 64'h000_0F0_00F);
    chk("t2b_latency", 64'(lat), 64'd9);
    hs1();

    send2(8'd123);
    chk("t3_digits", 64'(digits2), 64'h23);
    chk("t3_code", 64'(code2), 64'hF80_FF0);
    chk("t3_ovf", 64'(ovf2), 64'd1);
    hs2();
    send2(8'd99);
    chk("t3_99_digits", 64'(digits2), 64'h99);
    chk("t3_99_code", 64'(code2), 64'hFFF_FFF);
    chk("t3_99_ovf", 64'(ovf2), 64'd0);
    hs2();
    send2(8'd100);
    chk("t3_100_digits", 64'(digits2), 64'h00);
    chk("t3_100_ovf", 64'(ovf2), 64'd1);
    hs2();

    send1(8'd138, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_code", 64'(code), 64'hF00_FF0_F0F);
      chk("t4_hold_digits", 64'(digits), 64'h138);
      chk("t4_hold_ovf", 64'(ovf), 64'd0);
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_ready", 64'(in_ready), 64'd0);
    end
    hs1();

    @(negedge clk); in_valid = 1'b1; in_data = 8'd200;
    @(negedge clk); in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_code", 64'(code), 64'd0);
    chk("t5_digits", 64'(digits), 64'd0);
    chk("t5_ovf", 64'(ovf), 64'd0);
    @(negedge clk); rst = 1'b0;
    send1(8'd9, lat);
    chk("t5_new_digits", 64'(digits), 64'h009);
    chk("t5_new_code", 64'(code), 64'h000_000_FFF);
    hs1();

`ifdef DIGIT_COLOR_PALETTE_WR_EN
    @(negedge clk); pal_we = 1'b1; pal_addr = 4'd0;  pal_data = 12'h111;
    @(negedge clk); pal_we = 1'b1; pal_addr = 4'd12; pal_data = 12'hABC;
    @(negedge clk); pal_we = 1'b0;
    send1(8'd5, lat);
    chk("t6_code", 64'(code), 64'h111_111_0FF);
    chk("t6_digits", 64'(digits), 64'h005);
    hs1();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
